// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
// Bundles the three signal groups of the ROM stream reader: the command
// port, the sp_rom read pins and the valid/ready output stream.
//   master : the reader itself (drives status, ROM pins and stream)
//   slave  : the environment (command source, sp_rom, stream consumer)
interface rom_stream_reader_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int LENGTH_WIDTH  = 17
);

  // command / status
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] start_address;
  logic [LENGTH_WIDTH-1:0]  length;
  logic                     busy;
  logic                     done;

  // sp_rom read port
  logic [ADDRESS_WIDTH-1:0] rom_address;
  logic                     rom_ren;
  logic                     rom_cen;
  logic [DATA_WIDTH-1:0]    rom_data;

  // output stream
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    input  start,
    input  start_address,
    input  length,
    output busy,
    output done,
    output rom_address,
    output rom_ren,
    output rom_cen,
    input  rom_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    output start,
    output start_address,
    output length,
    input  busy,
    input  done,
    input  rom_address,
    input  rom_ren,
    input  rom_cen,
    output rom_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
// Burst read master for the sp_rom single-port synchronous ROM. A start
// command fetches a contiguous run of words; each word comes back one cycle
// after its read is issued and is buffered in a small FIFO that feeds a
// valid/ready stream with an end-of-burst flag (out_last).
//
// Build option:
//   ROM_READER_WRAP_EN defined   : addresses wrap past the top of the ROM and
//                                  the full requested length is delivered.
//   ROM_READER_WRAP_EN undefined : the length is clamped at start so the burst
//                                  stops at the top address.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | waiting for start; zero-length start only pulses done
//   S_FETCH | issuing reads while words remain and the FIFO has room
//   S_DRAIN | all reads issued; emptying FIFO until the last word is accepted
module rom_stream_reader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int LENGTH_WIDTH  = 17,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  rom_stream_reader_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LENGTH_WIDTH-1:0]  r_remaining;
  logic                     r_inflight;
  logic                     r_inflight_last;
  logic                     r_done;

  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_fifo_last;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [CNT_W-1:0]         r_count;

  logic                     w_start_ok;
  logic                     w_start_zero;
  logic                     w_start_burst;
  logic [LENGTH_WIDTH-1:0]  w_len_eff;
  logic                     w_out_valid;
  logic                     w_head_last;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last_pop;
  logic [CNT_W:0]           w_occupancy;
  logic [CNT_W:0]           w_limit;
  logic                     w_issue;
  logic                     w_issue_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Commands are only looked at while idle; a start during a burst is dropped.
  assign w_start_ok    = (r_state == S_IDLE) && bus.start;
  assign w_start_zero  = w_start_ok && (bus.length == '0);
  assign w_start_burst = w_start_ok && (bus.length != '0);

`ifdef ROM_READER_WRAP_EN
  // Address counter wraps naturally, so the requested length is used as is.
  assign w_len_eff = bus.length;
`else
  localparam int CW = (LENGTH_WIDTH > ADDRESS_WIDTH + 1) ? LENGTH_WIDTH : ADDRESS_WIDTH + 1;

  logic [CW-1:0] w_room;
  logic [CW-1:0] w_len_ext;

  // Words left between start_address and the top of the ROM (always >= 1).
  assign w_room    = (CW'(1) << ADDRESS_WIDTH) - CW'(bus.start_address);
  assign w_len_ext = CW'(bus.length);
  assign w_len_eff = (w_len_ext > w_room) ? LENGTH_WIDTH'(w_room) : bus.length;
`endif

  assign w_out_valid = (r_count != '0);
  assign w_head_last = r_fifo_last[r_rd_ptr];
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_last_pop  = w_pop && w_head_last;
  assign w_push      = r_inflight;

  // A read may be issued only if the word it returns is guaranteed a FIFO
  // slot: buffered + in-flight - leaving-this-cycle < depth. Written as
  // occupancy < depth + pop to stay unsigned.
  assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_limit      = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, w_pop};
  assign w_issue      = (r_state == S_FETCH) && (r_remaining != '0) && (w_occupancy < w_limit);
  assign w_issue_last = w_issue && (r_remaining == LENGTH_WIDTH'(1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_burst) w_state_next = S_FETCH;
      S_FETCH: if (w_issue_last)  w_state_next = S_DRAIN;
      S_DRAIN: if (w_last_pop)    w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs and stream view of the FIFO head
  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.done        = r_done;
    bus.rom_cen     = (r_state == S_FETCH);
    bus.rom_ren     = w_issue;
    bus.rom_address = r_addr;
    bus.out_valid   = w_out_valid;
    bus.out_data    = r_fifo_data[r_rd_ptr];
    bus.out_last    = w_out_valid && w_head_last;
  end

  // Burst address / remaining-word down-counter, in-flight tracking, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      if (w_start_burst) begin
        r_addr      <= bus.start_address;
        r_remaining <= w_len_eff;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDRESS_WIDTH'(1);
        r_remaining <= r_remaining - LENGTH_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      r_done          <= w_start_zero || w_last_pop;
    end
  end

  // Output FIFO: capture rom_data only in the cycle after an issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.rom_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
Read-side master for the sp_rom single-port synchronous ROM. On a start command it fetches a contiguous run of ROM words by driving the ROM's address/ren/cen pins. Fetched words are buffered in a small internal FIFO and presented as a valid/ready stream with an end-of-burst flag. It sits between sp_rom and any consumer (loader, DMA, test pattern source) that needs burst reads with backpressure.

Parameters:
ADDRESS_WIDTH, 16, ROM address width; must match sp_rom.
DATA_WIDTH, 16, ROM word width; must match sp_rom.
LENGTH_WIDTH, 17, burst length width; ADDRESS_WIDTH+1 allows a full-ROM burst.
FIFO_DEPTH, 4, output buffer entries; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  command strobe; sampled only when busy=0
start_address  input  ADDRESS_WIDTH  first ROM address of the burst
length  input  LENGTH_WIDTH  words to read; 0 is legal
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
rom_address  output  ADDRESS_WIDTH  to sp_rom address
rom_ren  output  1  to sp_rom ren
rom_cen  output  1  to sp_rom cen
rom_data  input  DATA_WIDTH  from sp_rom data; registered, 1-cycle latency
out_data  output  DATA_WIDTH  stream data (FIFO head)
out_valid  output  1  stream data valid
out_ready  input  1  consumer accept
out_last  output  1  qualifies the final word of the burst

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO flushed, counters cleared, FSM=IDLE. Applies mid-burst too: any in-flight ROM read is discarded and no done pulse is issued.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: start=1 with length>0 latches start_address and length, then moves to FETCH. busy=1 from the next cycle.
- IDLE, start=1 with length=0: no reads are issued and no stream output is produced. done=1 for one cycle on the next cycle, and busy stays 0.
- start while busy=1 is ignored.
- FETCH: rom_cen=1 throughout.
- FETCH issue rule: a read is issued (rom_ren=1, rom_address=current address) when words_remaining>0 and fifo_count + inflight - pop < FIFO_DEPTH.
  - inflight = read issued the previous cycle.
  - pop = out_valid & out_ready this cycle.
- On each issue: address increments by 1 and words_remaining decrements by 1.
- The FETCH-to-DRAIN transition occurs after the last issue.
- Capture: rom_data is pushed into the FIFO only in the cycle after an issue. sp_rom holds its output when ren=0, so it is never sampled otherwise.
- Latency: start sampled at edge N; first rom_ren at cycle N+1; first out_valid at cycle N+3.
- Throughput: 1 word/cycle with out_ready held 1.
- Backpressure: out_ready=0 holds out_data, out_valid and out_last stable. Issue stops once the FIFO plus the in-flight read would fill it, so there is never overflow or loss.
- out_last=1 exactly on the final word of the burst while it is at the FIFO head.
- DRAIN: rom_cen=0 and rom_ren=0. After the final word handshake, the next cycle has done=1 and busy=0, and the FSM returns to IDLE.
- A start in the same cycle as done is accepted.
- Width rule: address arithmetic is modulo 2**ADDRESS_WIDTH (see optional feature).

Optional Feature:
ROM_READER_WRAP_EN
- Defined: the address wraps from 2**ADDRESS_WIDTH-1 to 0, and the full length is always delivered.
- Undefined: length is clamped at start to 2**ADDRESS_WIDTH - start_address. The burst ends at the top address with out_last on that word, and no wrap occurs.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> all outputs 0 immediately; a burst restarted after release behaves normally.
- Normal burst: ROM preloaded mem[i]=i+0x100; start_address=0x0010, length=4, out_ready=1 -> rom_ren asserted 4 consecutive cycles from N+1; out_data 0x0110..0x0113 on cycles N+3..N+6; out_last with 0x0113; done at N+7.
- Backpressure: length=8, out_ready toggles 1,0,0,1,... -> all 8 words delivered in order with no duplicates, fifo never exceeds FIFO_DEPTH, and rom_ren stalls while the FIFO is full.
- Zero length: start, length=0 -> no rom_ren, no out_valid, done pulse one cycle later.
- Top-of-ROM: start_address=0xFFFE, length=4.
  - With ROM_READER_WRAP_EN: words from addresses FFFE, FFFF, 0000, 0001.
  - Without it: words from FFFE and FFFF only, out_last on FFFF.
- Abort and ignore: start while busy -> ignored. rst mid-FETCH -> stream stops, no done pulse; a new burst then completes correctly.
